// File: rtl/c3routing_avmm_hop.sv
// One hop of the per-channel AVMM daisy chain: routes upstream requests to the local
// slave or downstream, returns responses, and errors out requests nobody answers.
module c3routing_avmm_hop #(
  parameter int          CHNL_ID     = 0,
  parameter int          CHNL_W      = 6,
  parameter int          ADDR_W      = 17,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] ERR_RDATA   = 32'hBADC_0DE0
) (
  input  logic                     i_avmm_clk,
  input  logic                     i_avmm_rst,
  input  logic [ADDR_W+CHNL_W-1:0] i_addr,
  input  logic                     i_write,
  input  logic                     i_read,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_byteen,
  output logic [31:0]              o_rdata,
  output logic                     o_rdatavalid,
  output logic                     o_waitreq,
  output logic [ADDR_W-1:0]        o_lcl_addr,
  output logic                     o_lcl_write,
  output logic                     o_lcl_read,
  output logic [31:0]              o_lcl_wdata,
  output logic [3:0]               o_lcl_byteen,
  input  logic [31:0]              i_lcl_rdata,
  input  logic                     i_lcl_rdatavalid,
  input  logic                     i_lcl_waitreq,
  output logic [ADDR_W+CHNL_W-1:0] o_dn_addr,
  output logic                     o_dn_write,
  output logic                     o_dn_read,
  output logic [31:0]              o_dn_wdata,
  output logic [3:0]               o_dn_byteen,
  input  logic [31:0]              i_dn_rdata,
  input  logic                     i_dn_rdatavalid,
  input  logic                     i_dn_waitreq,
  output logic                     o_timeout_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CHNL_W-1:0] MY_CHNL  = CHNL_W'(CHNL_ID);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACK    = 2'd2,
    RDWAIT = 2'd3
  } state_t;

  state_t           state;
  logic             is_wr;
  logic             tgt_lcl;
  logic             rdv_held;
  logic             timed_out;
  logic [31:0]      rdata_held;
  logic [CNT_W-1:0] cnt;

  logic             sel_lcl;
  logic             tgt_waitreq;
  logic             tgt_rdv;
  logic [31:0]      tgt_rdata;

  assign sel_lcl     = (i_addr[ADDR_W+CHNL_W-1:ADDR_W] == MY_CHNL);
  assign tgt_waitreq = tgt_lcl ? i_lcl_waitreq    : i_dn_waitreq;
  assign tgt_rdv     = tgt_lcl ? i_lcl_rdatavalid : i_dn_rdatavalid;
  assign tgt_rdata   = tgt_lcl ? i_lcl_rdata      : i_dn_rdata;

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge i_avmm_clk or posedge i_avmm_rst) begin
    if (i_avmm_rst) begin
      state         <= IDLE;
      is_wr         <= 1'b0;
      tgt_lcl       <= 1'b0;
      rdv_held      <= 1'b0;
      timed_out     <= 1'b0;
      rdata_held    <= '0;
      cnt           <= '0;
      o_rdata       <= '0;
      o_rdatavalid  <= 1'b0;
      o_waitreq     <= 1'b1;
      o_lcl_addr    <= '0;
      o_lcl_write   <= 1'b0;
      o_lcl_read    <= 1'b0;
      o_lcl_wdata   <= '0;
      o_lcl_byteen  <= '0;
      o_dn_addr     <= '0;
      o_dn_write    <= 1'b0;
      o_dn_read     <= 1'b0;
      o_dn_wdata    <= '0;
      o_dn_byteen   <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      // Read data is a single-cycle pulse.
      o_rdatavalid <= 1'b0;
      o_rdata      <= '0;
      case (state)
        IDLE: begin
          o_waitreq <= 1'b1;
          if (i_read || i_write) begin
            is_wr     <= i_write;
            tgt_lcl   <= sel_lcl;
            rdv_held  <= 1'b0;
            timed_out <= 1'b0;
            cnt       <= '0;
            state     <= ISSUE;
            if (sel_lcl) begin
              o_lcl_addr   <= i_addr[ADDR_W-1:0];
              o_lcl_write  <= i_write;
              o_lcl_read   <= !i_write;
              o_lcl_wdata  <= i_wdata;
              o_lcl_byteen <= i_byteen;
            end else begin
              o_dn_addr   <= i_addr;
              o_dn_write  <= i_write;
              o_dn_read   <= !i_write;
              o_dn_wdata  <= i_wdata;
              o_dn_byteen <= i_byteen;
            end
          end
        end
        ISSUE: begin
          // A real accept wins over a timeout landing on the same edge.
          if (!tgt_waitreq || (cnt == CNT_LAST)) begin
            o_lcl_addr   <= '0;
            o_lcl_write  <= 1'b0;
            o_lcl_read   <= 1'b0;
            o_lcl_wdata  <= '0;
            o_lcl_byteen <= '0;
            o_dn_addr    <= '0;
            o_dn_write   <= 1'b0;
            o_dn_read    <= 1'b0;
            o_dn_wdata   <= '0;
            o_dn_byteen  <= '0;
            o_waitreq    <= 1'b0;
            state        <= ACK;
            if (tgt_waitreq) begin
              timed_out     <= 1'b1;
              o_timeout_err <= 1'b1;
            end else if (!is_wr && tgt_rdv) begin
              rdv_held   <= 1'b1;
              rdata_held <= tgt_rdata;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACK: begin
          o_waitreq <= 1'b1;
          if (is_wr) begin
            state <= IDLE;
          end else if (timed_out) begin
            o_rdatavalid <= 1'b1;
            o_rdata      <= ERR_RDATA;
            state        <= IDLE;
          end else if (rdv_held) begin
            o_rdatavalid <= 1'b1;
            o_rdata      <= rdata_held;
            state        <= IDLE;
          end else if (tgt_rdv) begin
            o_rdatavalid <= 1'b1;
            o_rdata      <= tgt_rdata;
            state        <= IDLE;
          end else begin
            cnt   <= '0;
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          o_waitreq <= 1'b1;
          if (tgt_rdv) begin
            o_rdatavalid <= 1'b1;
            o_rdata      <= tgt_rdata;
            state        <= IDLE;
          end else if (cnt == CNT_LAST) begin
            o_rdatavalid  <= 1'b1;
            o_rdata       <= ERR_RDATA;
            o_timeout_err <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          o_waitreq <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c3routing_avmm_hop.sv
// Scoreboard bench for c3routing_avmm_hop: behavioural local/downstream slaves,
// expected responses queued at issue time and compared when o_rdatavalid fires.
module tb_c3routing_avmm_hop;
  localparam int          CHNL_ID = 3;
  localparam int          CHNL_W  = 6;
  localparam int          ADDR_W  = 17;
  localparam int          TO      = 64;
  localparam logic [31:0] ERR     = 32'hBADC_0DE0;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [ADDR_W+CHNL_W-1:0] i_addr;
  logic                     i_write, i_read;
  logic [31:0]              i_wdata;
  logic [3:0]               i_byteen;
  logic [31:0]              o_rdata;
  logic                     o_rdatavalid, o_waitreq;
  logic [ADDR_W-1:0]        o_lcl_addr;
  logic                     o_lcl_write, o_lcl_read;
  logic [31:0]              o_lcl_wdata;
  logic [3:0]               o_lcl_byteen;
  logic [31:0]              i_lcl_rdata;
  logic                     i_lcl_rdatavalid, i_lcl_waitreq;
  logic [ADDR_W+CHNL_W-1:0] o_dn_addr;
  logic                     o_dn_write, o_dn_read;
  logic [31:0]              o_dn_wdata;
  logic [3:0]               o_dn_byteen;
  logic [31:0]              i_dn_rdata;
  logic                     i_dn_rdatavalid, i_dn_waitreq;
  logic                     o_timeout_err;

  always #5 clk = ~clk;

  c3routing_avmm_hop #(.CHNL_ID(CHNL_ID), .CHNL_W(CHNL_W), .ADDR_W(ADDR_W),
                       .TIMEOUT_CYC(TO), .ERR_RDATA(ERR)) dut (
    .i_avmm_clk(clk), .i_avmm_rst(rst),
    .i_addr(i_addr), .i_write(i_write), .i_read(i_read), .i_wdata(i_wdata), .i_byteen(i_byteen),
    .o_rdata(o_rdata), .o_rdatavalid(o_rdatavalid), .o_waitreq(o_waitreq),
    .o_lcl_addr(o_lcl_addr), .o_lcl_write(o_lcl_write), .o_lcl_read(o_lcl_read),
    .o_lcl_wdata(o_lcl_wdata), .o_lcl_byteen(o_lcl_byteen),
    .i_lcl_rdata(i_lcl_rdata), .i_lcl_rdatavalid(i_lcl_rdatavalid), .i_lcl_waitreq(i_lcl_waitreq),
    .o_dn_addr(o_dn_addr), .o_dn_write(o_dn_write), .o_dn_read(o_dn_read),
    .o_dn_wdata(o_dn_wdata), .o_dn_byteen(o_dn_byteen),
    .i_dn_rdata(i_dn_rdata), .i_dn_rdatavalid(i_dn_rdatavalid), .i_dn_waitreq(i_dn_waitreq),
    .o_timeout_err(o_timeout_err)
  );

  typedef struct {
    logic [31:0] data;
    int          t;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   tests = 0;
  int   fails = 0;

  // Per-transaction observations gathered by run_txn
  int                       lcl_wr_cyc, lcl_rd_cyc, dn_req_cyc, wlow_cnt, wlow_t, overlap;
  logic                     lcl_nz, dn_nz, stuck;
  logic [ADDR_W-1:0]        lcl_addr_seen;
  logic [31:0]              lcl_wdata_seen;
  logic [3:0]               lcl_be_seen;
  logic [ADDR_W+CHNL_W-1:0] dn_addr_seen;

  // Slave accepts after (acc+1) request cycles (acc<0: never); read data d cycles after accept.
  task automatic run_txn(input logic [22:0] addr, input logic wr, input logic rd,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int lcl_a, input int lcl_d, input logic [31:0] lcl_rd,
                         input int dn_a, input int dn_d, input logic [31:0] dn_rd);
    int   lcnt, dcnt, lacc, dacc, done_t;
    logic lrd, drd;
    rsp_t r;
    lcnt = 0; dcnt = 0; lacc = -1; dacc = -1; done_t = -1; lrd = 1'b0; drd = 1'b0;
    obs_q.delete();
    lcl_wr_cyc = 0; lcl_rd_cyc = 0; dn_req_cyc = 0; wlow_cnt = 0; wlow_t = -1; overlap = 0;
    lcl_nz = 1'b0; dn_nz = 1'b0; stuck = 1'b0;
    lcl_addr_seen = '0; lcl_wdata_seen = '0; lcl_be_seen = '0; dn_addr_seen = '0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (t == 0) begin
        i_addr = addr; i_write = wr; i_read = rd; i_wdata = wdata; i_byteen = be;
      end
      if (!o_waitreq) begin
        wlow_cnt++; wlow_t = t; i_write = 1'b0; i_read = 1'b0;
        if (wr && done_t < 0) done_t = t + 3;
      end
      if (o_rdatavalid) begin
        r.data = o_rdata; r.t = t; obs_q.push_back(r);
        if (!o_waitreq) overlap++;
        if (done_t < 0) done_t = t + 3;
      end
      if (|{o_lcl_addr, o_lcl_write, o_lcl_read, o_lcl_wdata, o_lcl_byteen}) lcl_nz = 1'b1;
      if (|{o_dn_addr, o_dn_write, o_dn_read, o_dn_wdata, o_dn_byteen}) dn_nz = 1'b1;
      if (o_lcl_write) lcl_wr_cyc++;
      if (o_lcl_read) lcl_rd_cyc++;
      if (o_lcl_write || o_lcl_read) begin
        lcl_addr_seen = o_lcl_addr; lcl_wdata_seen = o_lcl_wdata; lcl_be_seen = o_lcl_byteen;
      end
      if (o_dn_write || o_dn_read) begin
        dn_req_cyc++; dn_addr_seen = o_dn_addr;
      end
      i_lcl_waitreq = 1'b1; i_lcl_rdatavalid = 1'b0; i_lcl_rdata = '0;
      i_dn_waitreq  = 1'b1; i_dn_rdatavalid  = 1'b0; i_dn_rdata  = '0;
      if (lacc < 0 && lcl_a >= 0 && (o_lcl_write || o_lcl_read)) begin
        lcnt++;
        if (lcnt == lcl_a + 1) begin lacc = t; lrd = o_lcl_read; i_lcl_waitreq = 1'b0; end
      end
      if (lacc >= 0 && lrd && lcl_d >= 0 && t == lacc + lcl_d) begin
        i_lcl_rdatavalid = 1'b1; i_lcl_rdata = lcl_rd;
      end
      if (dacc < 0 && dn_a >= 0 && (o_dn_write || o_dn_read)) begin
        dcnt++;
        if (dcnt == dn_a + 1) begin dacc = t; drd = o_dn_read; i_dn_waitreq = 1'b0; end
      end
      if (dacc >= 0 && drd && dn_d >= 0 && t == dacc + dn_d) begin
        i_dn_rdatavalid = 1'b1; i_dn_rdata = dn_rd;
      end
      if (t == done_t) break;
    end
    if (done_t < 0) stuck = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests++;
    if (o_waitreq !== 1'b1) begin fails++; $display("FAIL reset_waitreq: got %b want 1", o_waitreq); end
    tests++;
    if ({o_rdata, o_rdatavalid, o_lcl_addr, o_lcl_write, o_lcl_read, o_lcl_wdata, o_lcl_byteen,
         o_dn_addr, o_dn_write, o_dn_read, o_dn_wdata, o_dn_byteen, o_timeout_err} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero, rdata=%h lcl_addr=%h dn_addr=%h",
                        o_rdata, o_lcl_addr, o_dn_addr);
    end
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++;
    if (o_waitreq !== 1'b1 || o_rdatavalid !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: waitreq=%b rdv=%b want 1/0", o_waitreq, o_rdatavalid);
    end
  endtask

  task automatic test_local_write();
    // accept after 3 request cycles: m=3, waitreq low at t=4
    run_txn({6'd3, 17'h0040}, 1'b1, 1'b0, 32'h1234_5678, 4'hF, 2, -1, '0, -1, -1, '0);
    tests++;
    if (stuck) begin fails++; $display("FAIL lw_done: got no completion want completion"); end
    tests++;
    if (lcl_wr_cyc !== 3 || lcl_rd_cyc !== 0) begin
      fails++; $display("FAIL lw_window: wr=%0d rd=%0d want 3/0", lcl_wr_cyc, lcl_rd_cyc);
    end
    tests++;
    if ({lcl_addr_seen, lcl_wdata_seen, lcl_be_seen} !== {17'h0040, 32'h1234_5678, 4'hF}) begin
      fails++; $display("FAIL lw_data: got %h %h %h want 00040 12345678 f",
                        lcl_addr_seen, lcl_wdata_seen, lcl_be_seen);
    end
    tests++;
    if (wlow_cnt !== 1 || wlow_t !== 4) begin
      fails++; $display("FAIL lw_ack: count=%0d t=%0d want 1/4", wlow_cnt, wlow_t);
    end
    tests++;
    if (dn_nz !== 1'b0 || obs_q.size() !== 0) begin
      fails++; $display("FAIL lw_quiet: dn_nz=%b rdv=%0d want 0/0", dn_nz, obs_q.size());
    end
  endtask

  task automatic test_local_read();
    int          acc_tab[2]  = '{0, 1};
    int          d_tab[2]    = '{3, 0};
    logic [31:0] data_tab[2] = '{32'hCAFE_F00D, 32'h0BAD_F00D};
    rsp_t        e, o;
    int          m, n;
    for (int i = 0; i < 2; i++) begin
      m = acc_tab[i] + 1;
      n = m + d_tab[i];
      e.data = data_tab[i];
      e.t = (n + 1 > m + 2) ? n + 1 : m + 2;
      exp_q.push_back(e);
      run_txn({6'd3, 17'h0100}, 1'b0, 1'b1, '0, 4'hF, acc_tab[i], d_tab[i], data_tab[i], -1, -1, '0);
      tests++;
      if (obs_q.size() !== 1) begin
        fails++; $display("FAIL lr%0d_count: got %0d responses want 1", i, obs_q.size());
        exp_q.delete();
      end else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        if (o.data !== e.data || o.t !== e.t) begin
          fails++; $display("FAIL lr%0d_resp: got %h@%0d want %h@%0d", i, o.data, o.t, e.data, e.t);
        end
      end
      tests++;
      if (wlow_t !== m + 1 || overlap !== 0 || dn_nz !== 1'b0) begin
        fails++; $display("FAIL lr%0d_ack: t=%0d overlap=%0d dn_nz=%b want %0d/0/0",
                          i, wlow_t, overlap, dn_nz, m + 1);
      end
    end
  endtask

  task automatic test_forward_read();
    rsp_t o, e;
    // downstream accepts after 2 request cycles (m=2), rdatavalid at edge 4 -> response t=5
    e.data = 32'hA5A5_0001; e.t = 5; exp_q.push_back(e);
    run_txn({6'd5, 17'h1_2345}, 1'b0, 1'b1, '0, 4'hF, -1, -1, '0, 1, 2, 32'hA5A5_0001);
    tests++;
    if (obs_q.size() !== 1) begin
      fails++; $display("FAIL fr_count: got %0d responses want 1", obs_q.size()); exp_q.delete();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.data !== e.data || o.t !== e.t) begin
        fails++; $display("FAIL fr_resp: got %h@%0d want %h@%0d", o.data, o.t, e.data, e.t);
      end
    end
    tests++;
    if (dn_addr_seen !== {6'd5, 17'h1_2345} || dn_req_cyc !== 2 || lcl_nz !== 1'b0) begin
      fails++; $display("FAIL fr_route: addr=%h cyc=%0d lcl_nz=%b want %h/2/0",
                        dn_addr_seen, dn_req_cyc, lcl_nz, {6'd5, 17'h1_2345});
    end
    tests++;
    if (o_timeout_err !== 1'b0) begin fails++; $display("FAIL no_err_yet: got %b want 0", o_timeout_err); end
  endtask

  task automatic test_chain_end();
    rsp_t o, e;
    // terminator never accepts: timeout at edge 64, ACK t=65, error data t=66
    e.data = ERR; e.t = TO + 2; exp_q.push_back(e);
    run_txn({6'd9, 17'h0004}, 1'b0, 1'b1, '0, 4'hF, -1, -1, '0, -1, -1, '0);
    tests++;
    if (obs_q.size() !== 1) begin
      fails++; $display("FAIL ce_count: got %0d responses want 1", obs_q.size()); exp_q.delete();
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.data !== e.data || o.t !== e.t) begin
        fails++; $display("FAIL ce_resp: got %h@%0d want %h@%0d", o.data, o.t, e.data, e.t);
      end
    end
    tests++;
    if (wlow_cnt !== 1 || wlow_t !== TO + 1 || dn_req_cyc !== TO) begin
      fails++; $display("FAIL ce_timing: acks=%0d t=%0d dncyc=%0d want 1/%0d/%0d",
                        wlow_cnt, wlow_t, dn_req_cyc, TO + 1, TO);
    end
    tests++;
    if (o_timeout_err !== 1'b1) begin fails++; $display("FAIL ce_err: got %b want 1", o_timeout_err); end
    run_txn({6'd3, 17'h0008}, 1'b1, 1'b0, 32'h0000_0001, 4'h1, 0, -1, '0, -1, -1, '0);
    tests++;
    if (o_timeout_err !== 1'b1 || lcl_wr_cyc !== 1) begin
      fails++; $display("FAIL ce_sticky: err=%b wr=%0d want 1/1", o_timeout_err, lcl_wr_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int   wr_c, rd_c, both, acks, rdv_c, phase;
    logic [31:0] got;
    wr_c = 0; rd_c = 0; both = 0; acks = 0; rdv_c = 0; phase = 0; got = '0;
    @(negedge clk);
    i_addr = {6'd3, 17'h0200}; i_wdata = 32'h7777_0000; i_byteen = 4'hF;
    i_write = 1'b1; i_read = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) @(negedge clk);
      if (o_lcl_write) wr_c++;
      if (o_lcl_read) rd_c++;
      if (o_lcl_write && o_lcl_read) both++;
      if (o_rdatavalid) begin rdv_c++; got = o_rdata; end
      i_lcl_waitreq = 1'b0;
      i_lcl_rdatavalid = o_lcl_read;
      i_lcl_rdata = o_lcl_read ? 32'h5A5A_1234 : '0;
      if (!o_waitreq) begin
        acks++;
        if (phase == 0) begin i_write = 1'b0; i_read = 1'b1; phase = 1; end
        else begin i_read = 1'b0; phase = 2; end
      end
    end
    i_lcl_waitreq = 1'b1; i_lcl_rdatavalid = 1'b0;
    tests++;
    if (wr_c !== 1 || rd_c !== 1 || both !== 0 || acks !== 2) begin
      fails++; $display("FAIL b2b_serial: wr=%0d rd=%0d both=%0d acks=%0d want 1/1/0/2",
                        wr_c, rd_c, both, acks);
    end
    tests++;
    if (rdv_c !== 1 || got !== 32'h5A5A_1234) begin
      fails++; $display("FAIL b2b_read: rdv=%0d data=%h want 1/5a5a1234", rdv_c, got);
    end
    run_txn({6'd3, 17'h0080}, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'h3, 0, 0, 32'h1111_1111, -1, -1, '0);
    tests++;
    if (lcl_wr_cyc !== 1 || lcl_rd_cyc !== 0 || obs_q.size() !== 0 ||
        lcl_wdata_seen !== 32'hDEAD_BEEF || lcl_be_seen !== 4'h3) begin
      fails++; $display("FAIL rw_as_write: wr=%0d rd=%0d rdv=%0d data=%h be=%h want 1/0/0/deadbeef/3",
                        lcl_wr_cyc, lcl_rd_cyc, obs_q.size(), lcl_wdata_seen, lcl_be_seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen, rdv_c;
    seen = 0; rdv_c = 0;
    @(negedge clk);
    i_addr = {6'd3, 17'h0010}; i_read = 1'b1; i_write = 1'b0;
    for (int t = 0; t < 20 && seen < 3; t++) begin
      @(negedge clk);
      if (seen > 0) seen++;
      if (!o_waitreq) begin seen = 1; i_read = 1'b0; end
      i_lcl_waitreq = !o_lcl_read;
    end
    i_lcl_waitreq = 1'b1;
    rst = 1'b1;
    #1;
    tests++;
    if (o_waitreq !== 1'b1 || o_timeout_err !== 1'b0 || o_rdatavalid !== 1'b0 || o_lcl_read !== 1'b0) begin
      fails++; $display("FAIL mid_reset: waitreq=%b err=%b rdv=%b lrd=%b want 1/0/0/0",
                        o_waitreq, o_timeout_err, o_rdatavalid, o_lcl_read);
    end
    @(negedge clk);
    rst = 1'b0;
    i_lcl_rdatavalid = 1'b1; i_lcl_rdata = 32'h1357_9BDF;
    @(negedge clk);
    i_lcl_rdatavalid = 1'b0; i_lcl_rdata = '0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (o_rdatavalid) rdv_c++;
    end
    tests++;
    if (rdv_c !== 0) begin fails++; $display("FAIL late_rdv: got %0d responses want 0", rdv_c); end
  endtask

  initial begin
    rst = 1'b1;
    i_addr = '0; i_write = 1'b0; i_read = 1'b0; i_wdata = '0; i_byteen = '0;
    i_lcl_rdata = '0; i_lcl_rdatavalid = 1'b0; i_lcl_waitreq = 1'b1;
    i_dn_rdata = '0; i_dn_rdatavalid = 1'b0; i_dn_waitreq = 1'b1;
    test_reset();
    test_local_write();
    test_local_read();
    test_forward_read();
    test_chain_end();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
